// File: rtl/demux_pkg.sv
// Shared definitions for the demux_stream block: select-width helper,
// drop counter sizing and the per-slot state encoding.
// Imported by demux_slot and demux_stream.
package demux_pkg;

  // Width of the saturating drop counter and its ceiling.
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // One-entry holding slot: either empty or holding a word.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // $clog2 that never returns 0, so a select bus is always at least 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready drain.
// Latency: load -> valid one cycle later. Backpressure: holds its word while ready=0;
// a draining slot may be reloaded in the same cycle for full throughput.
// Ports: clk, clr_n (sync active-low), load/load_data (write strobe + word),
//        ready (sink accepts), valid (slot full), data (slot word, 0 when empty if ZERO_IDLE).
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e      state_q;
  slot_state_e      state_d;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A drain with a simultaneous load keeps the slot full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (ready && !load) state_d = SLOT_EMPTY;
    endcase
  end

  // Data is only written on load; the top guarantees load only when the slot is free.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = (ZERO_IDLE && (state_q == SLOT_EMPTY)) ? '0 : data_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1:N stream demultiplexer with unicast/broadcast routing and per-channel slots.
// Latency: 1 cycle from accept to out_valid. Backpressure: in_ready drops only when a
// targeted slot is full and not draining; broadcast waits for every slot to be free.
// Ports: clk, clr_n (sync active-low); in_valid/in_ready/in_data/in_sel/in_bcast upstream;
//        out_valid/out_ready/out_data per channel (channel k at [k*WIDTH +: WIDTH]);
//        err_sel (one-cycle pulse on dropped out-of-range select), drop_cnt (saturating).
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int N_OUT     = 4,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [clog2_min1(N_OUT)-1:0] in_sel,
  input  logic                         in_bcast,
  output logic [N_OUT-1:0]             out_valid,
  input  logic [N_OUT-1:0]             out_ready,
  output logic [N_OUT*WIDTH-1:0]       out_data,
  output logic                         err_sel,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int SEL_W = clog2_min1(N_OUT);

  logic [N_OUT-1:0]      tmask;
  logic [N_OUT-1:0]      free;
  logic [N_OUT-1:0]      load;
  logic                  sel_bad;
  logic                  accept;
  logic                  err_q;
  logic [DROP_CNT_W-1:0] drop_q;

  // Target decode. An out-of-range select yields an empty mask, which makes
  // in_ready trivially 1 so the word is swallowed instead of stalling upstream.
  always_comb begin
    tmask   = '0;
    sel_bad = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      tmask[k] = in_bcast | (int'(in_sel) == k);
    end
    if (!in_bcast && (int'(in_sel) >= N_OUT)) begin
      sel_bad = 1'b1;
    end
  end

  // in_ready depends only on select, broadcast and slot status, never on in_valid.
  assign free     = ~out_valid | out_ready;
  assign in_ready = &(free | ~tmask);
  assign accept   = in_valid & in_ready;
  assign load     = {N_OUT{accept}} & tmask;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH    (WIDTH),
      .ZERO_IDLE(ZERO_IDLE)
    ) u_slot (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q <= accept & sel_bad;
      if (accept && sel_bad && (drop_q != DROP_CNT_MAX)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = drop_q;

  // SEL_W documents the select width for readers; tie it into a trivial check
  // so the localparam is not reported as unused.
  if (SEL_W < 1) begin : g_bad_sel_w
    $error("demux_stream: select width must be at least 1");
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream.
// dut "a": WIDTH=4, N_OUT=4, ZERO_IDLE=1. dut "b": WIDTH=4, N_OUT=3, ZERO_IDLE=0.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // dut a
  logic        clr_n;
  logic        a_in_valid, a_in_ready, a_in_bcast, a_err_sel;
  logic [3:0]  a_in_data, a_out_valid, a_out_ready;
  logic [1:0]  a_in_sel;
  logic [15:0] a_out_data;
  logic [7:0]  a_drop_cnt;

  // dut b
  logic        b_in_valid, b_in_ready, b_in_bcast, b_err_sel;
  logic [3:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [11:0] b_out_data;
  logic [7:0]  b_drop_cnt;

  demux_stream #(.WIDTH(4), .N_OUT(4), .ZERO_IDLE(1'b1)) dut_a (
    .clk(clk), .clr_n(clr_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .err_sel(a_err_sel), .drop_cnt(a_drop_cnt)
  );

  demux_stream #(.WIDTH(4), .N_OUT(3), .ZERO_IDLE(1'b0)) dut_b (
    .clk(clk), .clr_n(clr_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .err_sel(b_err_sel), .drop_cnt(b_drop_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    a_in_valid = 0; a_in_bcast = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_bcast = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 0;
    tick();
    tick();
    n_checks++;
    if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_a_valid: got %b want 0000", a_out_valid); end
    n_checks++;
    if (a_out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_a_data: got %h want 0000", a_out_data); end
    n_checks++;
    if (a_err_sel !== 1'b0 || a_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_a_err: got err=%b cnt=%0d want 0/0", a_err_sel, a_drop_cnt); end
    n_checks++;
    if (b_out_valid !== 3'b000 || b_out_data !== 12'h000) begin n_fail++; $display("FAIL reset_b: got v=%b d=%h want 000/000", b_out_valid, b_out_data); end
    clr_n = 1'b1;
  endtask

  task automatic test_unicast();
    a_in_sel = 2'd2; a_in_data = 4'hA; a_in_valid = 1'b1; a_out_ready = 4'b0000;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL uni_ready: got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if (a_out_valid !== 4'b0100) begin n_fail++; $display("FAIL uni_valid: got %b want 0100", a_out_valid); end
    n_checks++;
    if (a_out_data !== 16'h0A00) begin n_fail++; $display("FAIL uni_data: got %h want 0a00", a_out_data); end
  endtask

  task automatic test_backpressure();
    a_in_sel = 2'd2; a_in_data = 4'h3; a_in_valid = 1'b1; a_out_ready = 4'b0000;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b want 0", a_in_ready); end
    tick();
    n_checks++;
    if (a_out_data !== 16'h0A00 || a_out_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h want 0100/0a00", a_out_valid, a_out_data); end
    a_out_ready = 4'b0100;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0; a_out_ready = 4'b0000;
    n_checks++;
    if (a_out_valid !== 4'b0100 || a_out_data !== 16'h0300) begin n_fail++; $display("FAIL bp_reload: got v=%b d=%h want 0100/0300", a_out_valid, a_out_data); end
  endtask

  task automatic test_broadcast();
    // Fill slot 1 so it can stall the broadcast.
    a_in_sel = 2'd1; a_in_data = 4'h7; a_in_valid = 1'b1;
    tick();
    n_checks++;
    if (a_out_valid !== 4'b0110) begin n_fail++; $display("FAIL bc_prefill: got %b want 0110", a_out_valid); end
    a_in_bcast = 1'b1; a_in_sel = 2'd0; a_in_data = 4'h5; a_out_ready = 4'b1101;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bc_stall_ready: got %b want 0", a_in_ready); end
    tick();
    // Slot 2 drained without reload, slot 1 still holds 7, nothing loaded.
    n_checks++;
    if (a_out_valid !== 4'b0010 || a_out_data !== 16'h0070) begin n_fail++; $display("FAIL bc_noload: got v=%b d=%h want 0010/0070", a_out_valid, a_out_data); end
    a_out_ready = 4'b1111;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bc_release_ready: got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0; a_in_bcast = 1'b0; a_out_ready = 4'b0000;
    n_checks++;
    if (a_out_valid !== 4'b1111 || a_out_data !== 16'h5555) begin n_fail++; $display("FAIL bc_all: got v=%b d=%h want 1111/5555", a_out_valid, a_out_data); end
    a_out_ready = 4'b1111;
    tick();
    a_out_ready = 4'b0000;
    n_checks++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0000) begin n_fail++; $display("FAIL bc_drain: got v=%b d=%h want 0000/0000", a_out_valid, a_out_data); end
  endtask

  task automatic test_invalid_select();
    // Park a word in b slot 0 to show an invalid select leaves slots alone.
    b_in_sel = 2'd0; b_in_data = 4'h9; b_in_valid = 1'b1; b_out_ready = 3'b000;
    tick();
    b_in_sel = 2'd3; b_in_data = 4'hE;
    #1;
    n_checks++;
    if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready: got %b want 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    n_checks++;
    if (b_err_sel !== 1'b1 || b_drop_cnt !== 8'd1) begin n_fail++; $display("FAIL inv_first: got err=%b cnt=%0d want 1/1", b_err_sel, b_drop_cnt); end
    n_checks++;
    if (b_out_valid !== 3'b001 || b_out_data !== 12'h009) begin n_fail++; $display("FAIL inv_slots: got v=%b d=%h want 001/009", b_out_valid, b_out_data); end
    tick();
    n_checks++;
    if (b_err_sel !== 1'b0 || b_drop_cnt !== 8'd1) begin n_fail++; $display("FAIL inv_pulse: got err=%b cnt=%0d want 0/1", b_err_sel, b_drop_cnt); end
    b_in_valid = 1'b1;
    repeat (300) tick();
    b_in_valid = 1'b0;
    n_checks++;
    if (b_drop_cnt !== 8'd255 || b_err_sel !== 1'b1) begin n_fail++; $display("FAIL inv_sat: got cnt=%0d err=%b want 255/1", b_drop_cnt, b_err_sel); end
    tick();
    n_checks++;
    if (b_drop_cnt !== 8'd255) begin n_fail++; $display("FAIL inv_nowrap: got %0d want 255", b_drop_cnt); end
    // Drain slot 0: with ZERO_IDLE=0 the last word remains visible.
    b_out_ready = 3'b001;
    tick();
    b_out_ready = 3'b000;
    n_checks++;
    if (b_out_valid !== 3'b000 || b_out_data !== 12'h009) begin n_fail++; $display("FAIL inv_hold_idle: got v=%b d=%h want 000/009", b_out_valid, b_out_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    a_in_sel = 2'd0; a_out_ready = 4'b0001; a_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 4'(i);
      a_in_data = w;
      #1;
      n_checks++;
      if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, a_in_ready); end
      tick();
      n_checks++;
      if (a_out_valid !== 4'b0001 || a_out_data !== {12'h000, w}) begin n_fail++; $display("FAIL stream_word[%0d]: got v=%b d=%h want 0001/%h", i, a_out_valid, a_out_data, {12'h000, w}); end
    end
    a_in_valid = 1'b0;
    tick();
    a_out_ready = 4'b0000;
    n_checks++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0000) begin n_fail++; $display("FAIL stream_end: got v=%b d=%h want 0000/0000", a_out_valid, a_out_data); end
  endtask

  task automatic test_mid_reset();
    a_in_bcast = 1'b1; a_in_data = 4'hC; a_in_valid = 1'b1;
    b_in_bcast = 1'b1; b_in_data = 4'h6; b_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_bcast = 1'b0;
    b_in_valid = 1'b0; b_in_bcast = 1'b0;
    n_checks++;
    if (a_out_valid !== 4'b1111 || b_out_valid !== 3'b111 || b_out_data !== 12'h666) begin n_fail++; $display("FAIL mr_full: got a=%b b=%b bd=%h want 1111/111/666", a_out_valid, b_out_valid, b_out_data); end
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    n_checks++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0000 || a_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_a: got v=%b d=%h cnt=%0d want 0000/0000/0", a_out_valid, a_out_data, a_drop_cnt); end
    n_checks++;
    if (b_out_valid !== 3'b000 || b_out_data !== 12'h000 || b_drop_cnt !== 8'd0 || b_err_sel !== 1'b0) begin n_fail++; $display("FAIL mr_b: got v=%b d=%h cnt=%0d err=%b want 000/000/0/0", b_out_valid, b_out_data, b_drop_cnt, b_err_sel); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_invalid_select();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised, registered 1:N demultiplexer; next generation of the team's combinational 1:2 data DEMUX.
- Routes a WIDTH-bit word from one upstream source to one of N_OUT sinks, or to all of them in broadcast mode.
- Each output has a one-entry holding slot with valid/ready handshake, so slow sinks stall only the traffic aimed at them.
- Sits between the bus source (accumulator/ALU result) and multiple register/output-port consumers.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- N_OUT, 4, number of output channels (2..16).
- SEL_W, $clog2(N_OUT) (min 1), select width. Localparam, derived, not overridable.
- ZERO_IDLE, 1, 1: out_data of an empty slot reads 0; 0: an empty slot holds its last value.

Ports:
- clk  in  1  single system clock, rising edge.
- clr_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  upstream word.
- in_sel  in  SEL_W  target channel index.
- in_bcast  in  1  1 = deliver to all N_OUT channels; in_sel is ignored.
- out_valid  out  N_OUT  per-channel slot full.
- out_ready  in  N_OUT  per-channel sink accepts.
- out_data  out  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- err_sel  out  1  one-cycle pulse: an out-of-range in_sel was consumed.
- drop_cnt  out  8  saturating count of dropped (out-of-range) words.

Behaviour:
- Reset (clr_n=0 at a rising edge):
  - out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
  - Any word in flight is discarded; reset wins over every simultaneous event.
- Target mask T:
  - in_bcast=1: all ones.
  - in_sel<N_OUT: one-hot(in_sel).
  - in_sel>=N_OUT (only possible when N_OUT is not a power of 2): T=0, invalid select.
- Slot free condition: free[k] = !out_valid[k] | out_ready[k]. A slot draining this cycle may be reloaded in the same cycle.
- in_ready = &(free | ~T).
  - Combinational on in_sel, in_bcast, out_valid and out_ready.
  - Never depends on in_valid.
  - Broadcast is all-or-nothing: it waits until every slot is free.
- Accept event: in_valid & in_ready. For every k in T, slot k loads in_data and out_valid[k] is set next cycle. Latency is 1 cycle from accept to out_valid.
- Drain event: out_valid[k] & out_ready[k]. Clears out_valid[k] next cycle unless the same cycle also reloads slot k. That gives full throughput, one word per cycle per channel.
- Slots not in T and not draining hold their state.
- Invalid select:
  - The word is accepted (in_ready=1) and dropped; no slot changes.
  - err_sel=1 for exactly the next cycle.
  - drop_cnt increments, saturating at 255 with no wrap.
- out_data when out_valid[k]=0: 0 if ZERO_IDLE=1, otherwise the last loaded value. out_data stays stable while out_valid[k]=1 and out_ready[k]=0.
- in_valid=0: no slot loads; drains proceed normally.
- Per-slot FSM, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or on hold.
- No combinational path from in_valid or in_data to any output.

Decomposition:
- Shared package demux_pkg:
  - Function clog2_min1.
  - Constant DROP_CNT_W=8.
  - Constant DROP_CNT_MAX.
  - Slot state encoding: SLOT_EMPTY=1'b0, SLOT_FULL=1'b1.
- Sub-module demux_slot:
  - One-entry holding register with load, drain, valid and data ports, plus the ZERO_IDLE parameter.
  - Instantiated N_OUT times via generate.
- Top level keeps the target-mask decode, in_ready, err_sel and drop_cnt.

Test Plan:
- Reset then unicast: clr_n=0 for 2 cycles, then in_sel=2, in_data=4'hA, in_valid=1 for 1 cycle, out_ready=4'b0000.
  -> Next cycle out_valid=4'b0100, channel 2 data=4'hA, all other channels 0.
- Backpressure: slot 2 full, out_ready[2]=0, second word to channel 2.
  -> in_ready=0 and the data stays 4'hA. Raise out_ready[2].
  -> Same cycle in_ready=1; next cycle channel 2 holds the new word, out_valid[2] stays 1.
- Broadcast: in_bcast=1, in_data=4'h5, slot 1 full and stalled.
  -> in_ready=0 and no slot loads. Release slot 1.
  -> Next cycle out_valid=4'b1111, all channels 4'h5.
- Invalid select (N_OUT=3): in_sel=3, in_valid=1.
  -> in_ready=1, err_sel pulses 1 cycle, drop_cnt 0->1, out_valid unchanged. Repeat 300 times: drop_cnt=255.
- Streaming: channel 0 with out_ready[0]=1, 16 back-to-back words 0..F.
  -> in_ready stays 1 throughout; words appear in order, one per cycle, 1-cycle latency.
- Mid-operation reset: all slots full, clr_n=0 for 1 cycle.
  -> Next cycle out_valid=0, out_data=0, drop_cnt=0; ZERO_IDLE=0 build also shows data=0.
